ram_rd_seq: RTL and testbench

//  Read-side sequencer for the 5-bank rotating line/frame RAM controller. On each fsync it

---
 rtl/ram_rd_seq.sv | 142 ++++++++++++++
 tb/tb_ram_rd_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_seq.sv
// Read-side sequencer for the rotating line/frame RAM: walks R/L/P read addresses after each
// fsync and streams the returned words through a credit-counted skid FIFO.
module ram_rd_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 148,
  parameter int NUM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fsync,
  output logic [ADDR_WIDTH-1:0] R_R_addr,
  output logic [ADDR_WIDTH-1:0] R_L_addr,
  output logic [ADDR_WIDTH-1:0] R_P_addr,
  input  logic [DATA_WIDTH-1:0] R_R_data,
  input  logic [DATA_WIDTH-1:0] R_L_data,
  input  logic [DATA_WIDTH-1:0] R_P_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_l,
  output logic [DATA_WIDTH-1:0] out_p,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, READ, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] l;
    logic [DATA_WIDTH-1:0] p;
  } beat_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_addr;

  beat_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  beat_t                 head;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  last_accept;
  logic [CRD_W-1:0]      credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    head        = mem[rd_ptr];
    out_valid   = (fifo_cnt != '0);
    pop         = out_valid && out_ready;
    push        = inflight;
    last_accept = pop && (head.addr == LAST_ADDR);
    // Words already in flight must fit too; a same-cycle pop frees one slot.
    credit_used = CRD_W'(fifo_cnt) + CRD_W'(inflight) - CRD_W'(pop);
    issue       = (state == READ) && (credit_used < CRD_W'(FIFO_DEPTH));
  end

  assign R_R_addr   = rd_addr;
  assign R_L_addr   = rd_addr;
  assign R_P_addr   = rd_addr;
  assign out_addr   = out_valid ? head.addr : '0;
  assign out_r      = out_valid ? head.r    : '0;
  assign out_l      = out_valid ? head.l    : '0;
  assign out_p      = out_valid ? head.p    : '0;
  assign busy       = (state != IDLE);
  assign frame_done = last_accept;
  assign overrun    = fsync && (state != IDLE) && !last_accept;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (fsync) begin
      // The word in flight belongs to the old bank mapping and is dropped.
      state    <= ARM;
      rd_addr  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_addr <= rd_addr;
      case (state)
        ARM:   state <= READ;
        READ: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) state <= DRAIN;
            else                      rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: if (last_accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (fsync) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; the data outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: inflight_addr, r: R_R_data, l: R_L_data, p: R_P_data};
  end

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt == CNT_FULL)));

endmodule

// File: tb/tb_ram_rd_seq.sv
// Directed bench for ram_rd_seq: a NUM_WORDS=8 instance for timing and corner cases and a
// NUM_WORDS=16 instance for back-pressure; each RAM model tags data with frame id and channel.
module tb_ram_rd_seq;

  localparam int AW = 10;
  localparam int DW = 148;

  logic clk = 1'b0;
  logic rst_n;
  logic fsync;
  logic out_ready;
  logic [15:0] frame_id = 16'd0;

  always #5 clk = ~clk;

  logic [AW-1:0] ra8, la8, pa8, oa8;
  logic [DW-1:0] rd8, ld8, pd8, or8, ol8, op8;
  logic          v8, busy8, done8, ovr8;

  logic [AW-1:0] ra16, la16, pa16, oa16;
  logic [DW-1:0] rd16, ld16, pd16, or16, ol16, op16;
  logic          v16, busy16, done16, ovr16;

  ram_rd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .fsync(fsync),
    .R_R_addr(ra8), .R_L_addr(la8), .R_P_addr(pa8),
    .R_R_data(rd8), .R_L_data(ld8), .R_P_data(pd8),
    .out_valid(v8), .out_ready(out_ready), .out_addr(oa8),
    .out_r(or8), .out_l(ol8), .out_p(op8),
    .busy(busy8), .frame_done(done8), .overrun(ovr8)
  );

  ram_rd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(16), .FIFO_DEPTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .fsync(fsync),
    .R_R_addr(ra16), .R_L_addr(la16), .R_P_addr(pa16),
    .R_R_data(rd16), .R_L_data(ld16), .R_P_data(pd16),
    .out_valid(v16), .out_ready(out_ready), .out_addr(oa16),
    .out_r(or16), .out_l(ol16), .out_p(op16),
    .busy(busy16), .frame_done(done16), .overrun(ovr16)
  );

  function automatic logic [DW-1:0] mk(input logic [7:0] tag, input logic [15:0] fid,
                                       input logic [AW-1:0] a);
    return DW'({tag, fid, 6'd0, a});
  endfunction

  // One-cycle-latency RAM; the bank rotation happens at the fsync edge.
  always @(posedge clk) begin
    rd8  <= mk(8'h52, frame_id, ra8);
    ld8  <= mk(8'h4C, frame_id, la8);
    pd8  <= mk(8'h50, frame_id, pa8);
    rd16 <= mk(8'h52, frame_id, ra16);
    ld16 <= mk(8'h4C, frame_id, la16);
    pd16 <= mk(8'h50, frame_id, pa16);
    if (fsync) frame_id <= frame_id + 16'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fsync = 1'b0;
    repeat (n) tick();
  endtask

  // Collect one dut8 frame with out_ready=1; beats must be 0..n-1 of the current frame.
  task automatic collect_frame(input string name, input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (v8 && out_ready) begin
        check({name, "_addr"}, 32'(oa8), 32'(got));
        check_word({name, "_r"}, or8, mk(8'h52, frame_id, AW'(got)));
        check_word({name, "_l"}, ol8, mk(8'h4C, frame_id, AW'(got)));
        check_word({name, "_p"}, op8, mk(8'h50, frame_id, AW'(got)));
        check({name, "_done"}, 32'(done8), 32'(got == n - 1));
        got++;
      end
      tick();
      cyc++;
    end
    check({name, "_beats"}, 32'(got), 32'(n));
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy8), 32'(0));
    tick();
  endtask

  typedef struct {
    logic          fsync;
    logic          ready;
    logic          busy;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] oaddr;
    logic          done;
  } vec_t;

  function automatic vec_t v(input int fs, input int rdy, input int bsy, input int a,
                             input int vld, input int oa, input int dn);
    vec_t r;
    r.fsync = (fs != 0);
    r.ready = (rdy != 0);
    r.busy  = (bsy != 0);
    r.addr  = AW'(a);
    r.valid = (vld != 0);
    r.oaddr = AW'(oa);
    r.done  = (dn != 0);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t1 [13];
    logic [5:0]    rpat;
    logic [2:0]    ph;
    logic [AW-1:0] prev_oa;
    logic [DW-1:0] prev_r;
    logic          prev_stall;
    logic [31:0]   max_occ;
    int got, j, done_cnt, ovr_cnt, extra, vcnt, bcnt;

    //        fsync rdy busy addr valid oaddr done
    t1[0]  = v(1, 1, 0, 0, 0, 0, 0);
    t1[1]  = v(0, 1, 1, 0, 0, 0, 0);
    t1[2]  = v(0, 1, 1, 0, 0, 0, 0);
    t1[3]  = v(0, 1, 1, 1, 0, 0, 0);
    t1[4]  = v(0, 1, 1, 2, 1, 0, 0);
    t1[5]  = v(0, 1, 1, 3, 1, 1, 0);
    t1[6]  = v(0, 1, 1, 4, 1, 2, 0);
    t1[7]  = v(0, 1, 1, 5, 1, 3, 0);
    t1[8]  = v(0, 1, 1, 6, 1, 4, 0);
    t1[9]  = v(0, 1, 1, 7, 1, 5, 0);
    t1[10] = v(0, 1, 1, 7, 1, 6, 0);
    t1[11] = v(0, 1, 1, 7, 1, 7, 1);
    t1[12] = v(0, 1, 0, 7, 0, 0, 0);

    rst_n = 1'b0;
    fsync = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_valid", 32'(v8), 32'(0));
    check("rst_busy", 32'(busy8), 32'(0));
    check("rst_addr", {2'b0, ra8, la8, pa8}, 32'(0));
    check("rst_pulses", {30'b0, done8, ovr8}, 32'(0));
    check("rst_out_addr", 32'(oa8), 32'(0));
    check_word("rst_out_r", or8, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // T1: table-driven frame timing, NUM_WORDS=8, out_ready=1.
    for (int i = 0; i < 13; i++) begin
      fsync = t1[i].fsync;
      out_ready = t1[i].ready;
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", i), 32'(busy8), 32'(t1[i].busy));
      check($sformatf("t1_addr_c%0d", i), {2'b0, ra8, la8, pa8},
            {2'b0, t1[i].addr, t1[i].addr, t1[i].addr});
      check($sformatf("t1_valid_c%0d", i), 32'(v8), 32'(t1[i].valid));
      if (t1[i].valid) begin
        check($sformatf("t1_oaddr_c%0d", i), 32'(oa8), 32'(t1[i].oaddr));
        check_word($sformatf("t1_r_c%0d", i), or8, mk(8'h52, frame_id, t1[i].oaddr));
        check_word($sformatf("t1_l_c%0d", i), ol8, mk(8'h4C, frame_id, t1[i].oaddr));
        check_word($sformatf("t1_p_c%0d", i), op8, mk(8'h50, frame_id, t1[i].oaddr));
      end
      check($sformatf("t1_done_c%0d", i), 32'(done8), 32'(t1[i].done));
      check($sformatf("t1_ovr_c%0d", i), 32'(ovr8), 32'(0));
      tick();
    end
    idle(10);

    // T2: ready pattern 1,0,0,1,0,1 on the NUM_WORDS=16 instance.
    rpat = 6'b101001;
    got = 0; j = 0; done_cnt = 0; ovr_cnt = 0;
    prev_stall = 1'b0; prev_oa = '0; prev_r = '0; max_occ = 0;
    while (got < 16 && j < 400) begin
      ph = 3'(j % 6);
      fsync = (j == 0);
      out_ready = rpat[ph];
      @(negedge clk);
      if (32'(dut16.fifo_cnt) > max_occ) max_occ = 32'(dut16.fifo_cnt);
      if (prev_stall) begin
        check("t2_stall_valid", 32'(v16), 32'(1));
        check("t2_stall_addr", 32'(oa16), 32'(prev_oa));
        check_word("t2_stall_r", or16, prev_r);
      end
      if (v16 && out_ready) begin
        check("t2_addr", 32'(oa16), 32'(got));
        check_word("t2_r", or16, mk(8'h52, frame_id, AW'(got)));
        check_word("t2_p", op16, mk(8'h50, frame_id, AW'(got)));
        if (got == 15) check("t2_frame_done", 32'(done16), 32'(1));
        got++;
      end
      done_cnt += int'(done16);
      if (j != 0) ovr_cnt += int'(ovr16);
      prev_stall = v16 && !out_ready;
      prev_oa = oa16;
      prev_r = or16;
      tick();
      j++;
    end
    fsync = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      extra += int'(v16);
      done_cnt += int'(done16);
      tick();
    end
    check("t2_beats", 32'(got), 32'(16));
    check("t2_extra_beats", 32'(extra), 32'(0));
    check("t2_done_pulses", 32'(done_cnt), 32'(1));
    check("t2_overruns", 32'(ovr_cnt), 32'(0));
    check("t2_fifo_le_depth", 32'(max_occ <= 4), 32'(1));
    check("t2_busy_end", 32'(busy16), 32'(0));
    idle(10);

    // T3: fsync right after beat 5 is accepted aborts the frame.
    out_ready = 1'b1;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    got = 0; j = 0;
    while (got < 6 && j < 100) begin
      @(negedge clk);
      if (v8 && out_ready) begin
        check("t3_pre_addr", 32'(oa8), 32'(got));
        got++;
      end
      tick();
      j++;
    end
    check("t3_pre_beats", 32'(got), 32'(6));
    fsync = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t3_overrun_pulse", 32'(ovr8), 32'(1));
    tick();
    fsync = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_overrun_clear", 32'(ovr8), 32'(0));
    check("t3_flushed", 32'(v8), 32'(0));
    check("t3_busy", 32'(busy8), 32'(1));
    tick();
    collect_frame("t3", 8, 100);
    idle(5);

    // T4: out_ready low from the start; four credits then the address holds.
    out_ready = 1'b0;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("t4_addr_stall", {2'b0, ra8, la8, pa8}, {2'b0, 10'd4, 10'd4, 10'd4});
    check("t4_valid", 32'(v8), 32'(1));
    check("t4_head", 32'(oa8), 32'(0));
    tick();
    tick();
    @(negedge clk);
    check("t4_addr_held", 32'(ra8), 32'(4));
    check("t4_head_held", 32'(oa8), 32'(0));
    tick();
    out_ready = 1'b1;
    collect_frame("t4", 8, 100);
    idle(5);

    // T5: fsync coincides with acceptance of the final beat.
    out_ready = 1'b1;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    repeat (10) tick();
    fsync = 1'b1;
    @(negedge clk);
    check("t5_last_valid", 32'(v8), 32'(1));
    check("t5_last_addr", 32'(oa8), 32'(7));
    check_word("t5_last_r", or8, mk(8'h52, frame_id, AW'(7)));
    check("t5_frame_done", 32'(done8), 32'(1));
    check("t5_no_overrun", 32'(ovr8), 32'(0));
    tick();
    fsync = 1'b0;
    @(negedge clk);
    check("t5_rearmed", 32'(busy8), 32'(1));
    check("t5_valid_low", 32'(v8), 32'(0));
    tick();
    collect_frame("t5", 8, 100);
    idle(5);

    // T6: asynchronous reset in the middle of READ.
    out_ready = 1'b1;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    repeat (4) tick();
    check("t6_valid_before", 32'(v8), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(v8), 32'(0));
    check("t6_rst_busy", 32'(busy8), 32'(0));
    check("t6_rst_addr", {2'b0, ra8, la8, pa8}, 32'(0));
    check("t6_rst_done", 32'(done8), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vcnt = 0;
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      vcnt += int'(v8);
      bcnt += int'(busy8);
      tick();
    end
    check("t6_no_valid_after", 32'(vcnt), 32'(0));
    check("t6_no_busy_after", 32'(bcnt), 32'(0));
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    collect_frame("t6", 8, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
